// File: rtl/ntt_pkg.sv
// Shared types and default sizes for the NTT coefficient front end.
package ntt_pkg;

  localparam int NTT_DATA_W = 16;
  localparam int NTT_ADDR_W = 8;
  localparam int NTT_N      = 256;

  // Frame sequencing states of the coefficient loader.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_KICK = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } ld_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra wrap bit on each pointer so that full
// and empty are told apart without a separate counter. The head entry is
// presented combinationally from the registered read pointer, so a beat
// written at one edge can be popped at the next.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign level   = wr_ptr_r - rd_ptr_r;
  assign rd_en_s = pop && !empty;
  // A push into a full FIFO only lands when a pop frees the slot this cycle.
  assign wr_en_s = push && (!full || rd_en_s);
  assign dout    = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; both pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= (AW+1)'(0);
      rd_ptr_r <= (AW+1)'(0);
    end else if (clr) begin
      wr_ptr_r <= (AW+1)'(0);
      rd_ptr_r <= (AW+1)'(0);
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ntt_coef_loader.sv
// Host-to-NTT coefficient loader: buffers multi-lane beats, streams one
// frame into the core write ports with generated addresses, kicks the
// core and reports completion.
module ntt_coef_loader
  import ntt_pkg::*;
#(
  parameter int DATA_W = NTT_DATA_W,
  parameter int ADDR_W = NTT_ADDR_W,
  parameter int LANES  = 2,
  parameter int N      = NTT_N,
  parameter int DEPTH  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      start,
  input  logic                      mode,
  input  logic [LANES*DATA_W-1:0]   s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      core_we,
  output logic [LANES*ADDR_W-1:0]   core_addr,
  output logic [LANES*DATA_W-1:0]   core_data,
  output logic                      core_start,
  output logic                      core_mode,
  input  logic                      core_done,
  output logic                      busy,
  output logic                      in_done,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int BEATS = N / LANES;
  localparam int KW    = $clog2(BEATS + 1);

  ld_state_t                 state_r;
  ld_state_t                 state_next_s;
  logic [KW-1:0]             k_r;
  logic                      pop_s;
  logic                      push_s;
  logic                      last_beat_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [LANES*DATA_W-1:0]   fifo_dout_s;

  logic                      core_we_r;
  logic [LANES*ADDR_W-1:0]   core_addr_r;
  logic [LANES*DATA_W-1:0]   core_data_r;
  logic                      core_start_r;
  logic                      core_mode_r;
  logic                      busy_r;
  logic                      in_done_r;
  logic                      done_r;

  assign s_ready     = !fifo_full_s;
  assign push_s      = s_valid && s_ready;
  assign pop_s       = (state_r == ST_FILL) && !fifo_empty_s;
  assign last_beat_s = (k_r == KW'(BEATS - 1));

  sync_fifo #(
    .WIDTH (LANES*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_s),
    .pop   (pop_s),
    .din   (s_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (level)
  );

  // State register; clr abandons any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else if (clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; start and core_done only matter in their own states.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_FILL;
        else       state_next_s = ST_IDLE;
      end
      ST_FILL: begin
        if (pop_s && last_beat_s) state_next_s = ST_KICK;
        else                      state_next_s = ST_FILL;
      end
      ST_KICK: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (core_done) state_next_s = ST_DONE;
        else           state_next_s = ST_WAIT;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Beat counter and direction latch, both armed by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_r         <= KW'(0);
      core_mode_r <= 1'b0;
    end else if (clr) begin
      k_r         <= KW'(0);
    end else if ((state_r == ST_IDLE) && start) begin
      k_r         <= KW'(0);
      core_mode_r <= mode;
    end else if (pop_s) begin
      k_r         <= k_r + KW'(1);
    end
  end

  // Registered core-side outputs; strobes are one cycle behind the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_we_r    <= 1'b0;
      core_addr_r  <= '0;
      core_data_r  <= '0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      in_done_r    <= 1'b0;
      done_r       <= 1'b0;
    end else if (clr) begin
      core_we_r    <= 1'b0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      in_done_r    <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      core_we_r    <= pop_s;
      core_start_r <= (state_r == ST_KICK);
      busy_r       <= (state_next_s != ST_IDLE);
      in_done_r    <= pop_s && last_beat_s;
      done_r       <= (state_r == ST_DONE);
      if (pop_s) begin
        core_data_r <= fifo_dout_s;
        for (int l = 0; l < LANES; l++) begin
          core_addr_r[l*ADDR_W +: ADDR_W] <= ADDR_W'(int'(k_r) * LANES + l);
        end
      end
    end
  end

  assign core_we    = core_we_r;
  assign core_addr  = core_addr_r;
  assign core_data  = core_data_r;
  assign core_start = core_start_r;
  assign core_mode  = core_mode_r;
  assign busy       = busy_r;
  assign in_done    = in_done_r;
  assign done       = done_r;

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Self-checking bench for ntt_coef_loader: a queue-based frame model checks
// the main instance every cycle, and a shallow-FIFO instance covers the
// full/back-pressure boundary with directed checks.
module tb_ntt_coef_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int LANES  = 2;
  localparam int N      = 256;
  localparam int DEPTH  = 256;
  localparam int SDEPTH = 4;
  localparam int BEATS  = N / LANES;

  typedef logic [LANES*DATA_W-1:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0, start = 1'b0, mode = 1'b0, s_valid = 1'b0, core_done = 1'b0;
  beat_t s_data = '0;
  logic s_ready, core_we, core_start, core_mode, busy, in_done, done;
  logic [LANES*ADDR_W-1:0] core_addr;
  beat_t core_data;
  logic [$clog2(DEPTH):0] level;

  logic sm_clr = 1'b0, sm_start = 1'b0, sm_mode = 1'b0, sm_s_valid = 1'b0, sm_core_done = 1'b0;
  beat_t sm_s_data = '0;
  logic sm_s_ready, sm_core_we, sm_core_start, sm_core_mode, sm_busy, sm_in_done, sm_done;
  logic [LANES*ADDR_W-1:0] sm_core_addr;
  beat_t sm_core_data;
  logic [$clog2(SDEPTH):0] sm_level;

  always #5 clk = ~clk;

  ntt_coef_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .core_we(core_we), .core_addr(core_addr), .core_data(core_data),
    .core_start(core_start), .core_mode(core_mode), .core_done(core_done),
    .busy(busy), .in_done(in_done), .done(done), .level(level));

  ntt_coef_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .N(N), .DEPTH(SDEPTH)) dut_small (
    .clk(clk), .rst(rst), .clr(sm_clr), .start(sm_start), .mode(sm_mode),
    .s_data(sm_s_data), .s_valid(sm_s_valid), .s_ready(sm_s_ready),
    .core_we(sm_core_we), .core_addr(sm_core_addr), .core_data(sm_core_data),
    .core_start(sm_core_start), .core_mode(sm_core_mode), .core_done(sm_core_done),
    .busy(sm_busy), .in_done(sm_in_done), .done(sm_done), .level(sm_level));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk(input logic [15:0] base, input int i);
    return {DATA_W'(int'(base) + 2*i + 1), DATA_W'(int'(base) + 2*i)};
  endfunction

  // ---------------- frame model of the main instance ----------------
  beat_t q[$];
  bit    m_loading, m_kick, m_waiting, m_finishing, m_mode;
  int    m_beats;
  bit    m_idle, m_pop, m_acc;
  bit    e_we, e_in_done, e_start, e_done, e_busy;
  logic [LANES*ADDR_W-1:0] e_addr;
  beat_t e_data;

  // Advances the model by one clock edge using the inputs seen at that edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      {m_loading, m_kick, m_waiting, m_finishing, m_mode} = '0;
      {e_we, e_in_done, e_start, e_done, e_busy} = '0;
      m_beats = 0;
    end else if (clr) begin
      q.delete();
      {m_loading, m_kick, m_waiting, m_finishing} = '0;
      {e_we, e_in_done, e_start, e_done, e_busy} = '0;
    end else begin
      m_idle = !(m_loading || m_kick || m_waiting || m_finishing);
      m_pop  = m_loading && (q.size() > 0);
      m_acc  = s_valid && (q.size() < DEPTH);
      e_start = m_kick;
      e_done  = m_finishing;
      e_we    = m_pop;
      e_in_done = 1'b0;
      m_finishing = m_waiting && core_done;
      if (m_finishing) m_waiting = 1'b0;
      if (m_kick) begin
        m_kick = 1'b0;
        m_waiting = 1'b1;
      end
      if (m_pop) begin
        e_data = q.pop_front();
        for (int l = 0; l < LANES; l++) e_addr[l*ADDR_W +: ADDR_W] = ADDR_W'(m_beats*LANES + l);
        if (m_beats == BEATS-1) begin
          e_in_done = 1'b1;
          m_loading = 1'b0;
          m_kick = 1'b1;
        end
        m_beats++;
      end
      if (m_acc) q.push_back(s_data);
      if (m_idle && start) begin
        m_loading = 1'b1;
        m_beats = 0;
        m_mode = mode;
      end
      e_busy = m_loading || m_kick || m_waiting || m_finishing;
    end
  end

  // Compares the main instance against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("we", core_we, e_we);
      check("in_done", in_done, e_in_done);
      check("core_start", core_start, e_start);
      check("done", done, e_done);
      check("busy", busy, e_busy);
      check("core_mode", core_mode, m_mode);
      check("level", level, 64'(q.size()));
      check("s_ready", s_ready, q.size() < DEPTH);
      if (e_we) begin
        check("addr", core_addr, e_addr);
        check("data", core_data, e_data);
      end
    end
  end

  int we_count = 0;
  beat_t sm_data_q[$];
  logic [LANES*ADDR_W-1:0] sm_addr_q[$];

  // Counts main-instance writes and records the shallow instance's writes.
  always @(negedge clk) begin
    if (core_we) we_count++;
    if (sm_core_we) begin
      sm_data_q.push_back(sm_core_data);
      sm_addr_q.push_back(sm_core_addr);
    end
  end

  initial begin
    int b;
    int wc;
    int idx;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_we", core_we, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_in_done", in_done, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", core_addr, 0);
    check("rst_data", core_data, 0);
    check("rst_mode", core_mode, 1'b0);
    check("rst_sm_s_ready", sm_s_ready, 1'b1);
    chk_en = 1'b1;
    rst = 1'b1;
    tick();

    // ---------------- full FIFO on the shallow instance ----------------
    for (int i = 0; i < 4; i++) begin
      sm_s_valid = 1'b1;
      sm_s_data = mk(16'h5000, i);
      tick();
    end
    check("full_level", sm_level, 4);
    check("full_s_ready", sm_s_ready, 1'b0);
    sm_s_data = mk(16'h5000, 4);
    tick();
    tick();
    check("full_hold_level", sm_level, 4);
    sm_start = 1'b1;
    tick();
    sm_start = 1'b0;
    for (int i = 4; i < 6; i++) begin
      sm_s_data = mk(16'h5000, i);
      sm_s_valid = 1'b1;
      b = 0;
      while (!sm_s_ready && b < 20) begin
        tick();
        b++;
      end
      if (b >= 20) timeout("full_ready_wait");
      tick();
    end
    sm_s_valid = 1'b0;
    repeat (6) tick();
    check("full_write_count", sm_data_q.size(), 6);
    for (int i = 0; i < 6 && i < sm_data_q.size(); i++) begin
      check("full_order_data", sm_data_q[i], mk(16'h5000, i));
      check("full_order_addr", sm_addr_q[i], {ADDR_W'(2*i+1), ADDR_W'(2*i)});
    end
    sm_clr = 1'b1;
    tick();
    sm_clr = 1'b0;
    check("sm_clr_busy", sm_busy, 1'b0);
    check("sm_clr_level", sm_level, 0);

    // ---------------- frame load with a full frame buffered ----------------
    for (int i = 0; i < BEATS; i++) begin
      s_valid = 1'b1;
      s_data = mk(16'h0000, i);
      tick();
    end
    s_valid = 1'b0;
    check("preload_level", level, 128);
    mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_first_gap", core_we, 1'b0);
    for (int i = 0; i < BEATS; i++) begin
      tick();
      check("load_we", core_we, 1'b1);
      if (i == 0) begin
        check("load_addr0", core_addr, 16'h0100);
        check("load_data0", core_data, 32'h0001_0000);
      end
      if (i == BEATS-1) begin
        check("load_in_done", in_done, 1'b1);
        check("load_addr_last", core_addr, 16'hFFFE);
        check("load_data_last", core_data, 32'h00FF_00FE);
      end else begin
        check("load_in_done_early", in_done, 1'b0);
      end
    end
    tick();
    check("kick", core_start, 1'b1);
    check("kick_we", core_we, 1'b0);
    tick();
    check("kick_once", core_start, 1'b0);
    check("wait_busy", busy, 1'b1);

    // ---------------- handshake gating ----------------
    mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 1'b0;
    check("start_in_wait_mode", core_mode, 1'b0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    check("done_pulse", done, 1'b1);
    check("done_idle", busy, 1'b0);
    tick();
    check("done_once", done, 1'b0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    repeat (3) tick();
    check("core_done_idle", done, 1'b0);

    // ---------------- underrun stall, mode latch, ignored core_done ----------------
    wc = we_count;
    mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      s_data = mk(16'hA000, i);
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      mode = ~mode;
      if (i == 20) core_done = 1'b1;
      tick();
      core_done = 1'b0;
      tick();
    end
    check("stall_writes", we_count - wc, 128);
    check("mode_latched", core_mode, 1'b1);
    // preload the next frame while the core runs
    for (int i = 0; i < 10; i++) begin
      s_data = mk(16'h3000, i);
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    check("preload_wait_level", level, 10);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    repeat (2) tick();
    check("mode_after_frame", core_mode, 1'b1);

    // ---------------- async reset mid-frame ----------------
    wc = we_count;
    idx = 10;
    mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    b = 0;
    s_valid = 1'b1;
    while ((we_count - wc) < 40 && b < 400) begin
      s_data = mk(16'h3000, idx);
      idx++;
      tick();
      b++;
    end
    if (b >= 400) timeout("reset_beat_wait");
    s_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_level", level, 0);
    check("arst_we", core_we, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // ---------------- synchronous clear mid-frame ----------------
    for (int i = 0; i < 20; i++) begin
      s_data = mk(16'h7000, i);
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", busy, 1'b0);
    check("clr_level", level, 0);
    check("clr_we", core_we, 1'b0);

    // ---------------- fresh frame restarts at address 0 ----------------
    for (int i = 0; i < BEATS; i++) begin
      s_data = mk(16'h9000, i);
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("fresh_we", core_we, 1'b1);
    check("fresh_addr0", core_addr, 16'h0100);
    check("fresh_data0", core_data, 32'h9001_9000);
    b = 0;
    while (!in_done && b < 200) begin
      tick();
      b++;
    end
    if (b >= 200) timeout("fresh_in_done_wait");
    repeat (2) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_coef_loader.md
# ntt_coef_loader

Parametrised single-clock successor to the host-to-NTT FIFO front end. It buffers multi-lane coefficient beats from the host in an internal synchronous FIFO, then on `start` streams exactly one frame of N coefficients into the NTT core's write port with generated addresses. It then pulses the core start, waits for the core's completion and reports frame status. It sits between the HPS-facing bridge and `wrap`, replacing the fixed two-lane dual-clock FIFO pair and its address/data packing.

## Interface
- `DATA_W`, 16: coefficient width.
- `ADDR_W`, 8: core address width; requires N ≤ 2^ADDR_W.
- `LANES`, 2: coefficients per beat; each lane has its own core write port; requires N % LANES == 0.
- `N`, 256: coefficients per frame.
- `DEPTH`, 256: FIFO depth in beats; power of two, ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `clr`  in  1: synchronous flush; empties the FIFO and returns to IDLE.
- `start`, `mode`  in  1 each: frame start; transform direction (0 = forward, 1 = inverse).
- `s_data`  in  LANES*DATA_W: host beat; lane l is bits [l*DATA_W +: DATA_W].
- `s_valid`, `s_ready`  in, out  1 each: host handshake.
- `core_we`  out  1: core write strobe.
- `core_addr`  out  LANES*ADDR_W: per-lane write addresses.
- `core_data`  out  LANES*DATA_W: per-lane write data.
- `core_start`, `core_mode`  out  1 each: core kick pulse; latched direction.
- `core_done`  in  1: core completion pulse.
- `busy`, `in_done`, `done`  out  1 each: frame active; load-complete pulse; frame-complete pulse.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy in beats.

## Operation
- States are IDLE, FILL, KICK, WAIT and DONE.
- IDLE: `start` latches `mode` into `core_mode`, clears the beat counter k and moves to FILL. `start` in any other state is ignored.
- FILL: each cycle the FIFO is non-empty, pop one beat and drive `core_we`=1.
  - Lane l address is k*LANES+l. Lane l data is the popped lane l.
  - k increments per beat. An empty FIFO stalls with `core_we`=0, and k holds.
  - After beat N/LANES-1: pulse `in_done`, go to KICK.
- KICK: `core_start`=1 for exactly one cycle, then WAIT.
- WAIT: on `core_done`, go to DONE. `core_done` in any other state is ignored.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy` = (state ≠ IDLE).
- Host writes are accepted in every state, so the next frame preloads during WAIT. `s_ready` = (level < DEPTH).
- FIFO boundaries:
  - Push only when full: the beat is held by the handshake and nothing is lost.
  - Simultaneous push and pop when full: allowed; `level` is unchanged and `s_ready` stays 0 that cycle.
  - Simultaneous push and pop when empty: the pushed beat is not bypassed; it is popped the following cycle.
  - Pointers wrap modulo DEPTH.
- Address arithmetic is unsigned, truncated to ADDR_W. The parameter rules guarantee no overflow.
- `clr`, or `rst` low, in any state: state→IDLE, FIFO emptied, all pulses dropped. A partially loaded frame is abandoned, and the core must be reset separately.

## Timing
- Reset values:
  - `s_ready`=1 (DEPTH > 0).
  - `core_we`, `core_start`, `in_done`, `done` and `busy` = 0.
  - `core_addr`, `core_data`, `core_mode` and `level` = 0.
- All outputs are registered, except `s_ready` and `level`, which decode registered counters.
- FIFO write-to-read latency: a beat pushed at edge t is poppable at edge t+1.
- Load latency: `start` at edge t with a full frame buffered gives `core_we` high on cycles t+1 … t+N/LANES, and `in_done` with the last beat.
- `core_start` is high on cycle t+N/LANES+1.
- `done` is high exactly one cycle after the `core_done` edge.

## Structure
- Package `ntt_pkg` holds the state enum `ld_state_t` and the shared constants (`DATA_W`, `ADDR_W` and `N` defaults).
- Sub-module `sync_fifo` is parametrised by WIDTH and DEPTH. It provides push, pop, dout, full, empty and level, and implements the registered read and wrap pointers with an extra wrap bit.

## Test plan
- Frame load:
  - Stimulus: LANES=2, N=256; push 128 beats {2k+1, 2k}; pulse `start`.
  - Required: 128 consecutive `core_we` cycles with addresses (2k, 2k+1) and data matching; `in_done` on beat 127; `core_start` exactly one cycle later.
- Underrun stall:
  - Stimulus: push beats one every 3 cycles during FILL.
  - Required: `core_we` only on pop cycles, k unchanged across gaps, 128 writes total.
- Full FIFO:
  - Stimulus: DEPTH=4; push 6 beats with no pops.
  - Required: `s_ready` falls after 4 pushes, `level`=4; the remaining 2 beats are accepted in order once FILL begins.
- Handshake gating:
  - Stimulus: `core_done` pulse in IDLE or FILL, and `start` in WAIT.
  - Required: both ignored. A `core_done` in WAIT gives `done` one cycle later, then IDLE.
- Reset mid-frame:
  - Stimulus: assert `rst` low (or `clr`) mid-FILL at beat 40.
  - Required: `busy`=0, `level`=0 and `core_we`=0 at once. A fresh frame afterwards starts at address 0.
- Mode latch:
  - Stimulus: `start` with `mode`=1, then toggle `mode` during FILL.
  - Required: `core_mode` stays 1 until the next `start`.
